// File: rtl/dmx_pkg.sv
// Shared types and constants for the DMX512 transmitter.
package dmx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_BREAK, ST_MAB, ST_START, ST_DATA, ST_STOP, ST_MTBF
  } dmx_state_e;

  localparam int         DMX_SLOT_BITS  = 11;
  localparam int         DMX_MAX_SLOTS  = 512;
  localparam logic [7:0] DMX_START_CODE = 8'h00;

  function automatic int dmx_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dmx_bit_timer.sv
// Line-bit timer: counts CLKS_PER_BIT cycles per bit and pulses bit_tick on the last one.
module dmx_bit_timer #(
  parameter int CLKS_PER_BIT = 108
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [TW-1:0] tick_q, tick_d;

  assign bit_tick = run && (tick_q == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    tick_d = tick_q;
    if (clear)    tick_d = '0;
    else if (run) tick_d = bit_tick ? '0 : tick_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) tick_q <= '0;
    else     tick_q <= tick_d;

endmodule

// File: rtl/dmx_transmitter.sv
// DMX512 universe serialiser: BREAK, MAB, start code, NUM_SLOTS slots, optional MTBF.
// Define DMX_FRAME_CNT_EN to add the frame_count output.
module dmx_transmitter import dmx_pkg::*; #(
  parameter int         CLKS_PER_BIT = 108,
  parameter int         BREAK_BITS   = 23,
  parameter int         MAB_BITS     = 3,
  parameter int         NUM_SLOTS    = 512,
  parameter int         MTBF_BITS    = 0,
  parameter logic [7:0] START_CODE   = DMX_START_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [8:0] slot_index,
  input  logic [7:0] slot_data,
  output logic       tx,
  output logic       busy,
  output logic       frame_start,
  output logic       frame_done
`ifdef DMX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int BIT_MAX = dmx_max(dmx_max(BREAK_BITS, MAB_BITS), dmx_max(MTBF_BITS, DMX_SLOT_BITS));
  localparam int BCW     = $clog2(BIT_MAX + 1);
  localparam int SW      = $clog2(DMX_MAX_SLOTS + 1);

  localparam logic [BCW-1:0] BRK_LAST  = BCW'(BREAK_BITS - 1);
  localparam logic [BCW-1:0] MAB_LAST  = BCW'(MAB_BITS - 1);
  localparam logic [BCW-1:0] MTBF_LAST = BCW'((MTBF_BITS > 0) ? MTBF_BITS - 1 : 0);

  dmx_state_e     state_q, state_d;
  logic [BCW-1:0] bit_q, bit_d, bit_last;
  logic [SW-1:0]  slot_q, slot_d;
  logic [7:0]     shift_q, shift_d;
  logic [8:0]     idx_q, idx_d;
  logic           tx_q, tx_d, fs_q, fs_d;
  logic           bit_tick, seg_done, more_slots;

  dmx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .clear    (state_q == ST_IDLE),
    .run      (state_q != ST_IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    bit_last = '0;
    case (state_q)
      ST_BREAK: bit_last = BRK_LAST;
      ST_MAB:   bit_last = MAB_LAST;
      ST_DATA:  bit_last = BCW'(7);
      ST_STOP:  bit_last = BCW'(1);
      ST_MTBF:  bit_last = MTBF_LAST;
      default:  bit_last = '0;
    endcase
  end

  assign seg_done   = bit_tick && (bit_q == bit_last);
  assign more_slots = slot_q < SW'(NUM_SLOTS);
  // Final edge of the frame: end of MTBF, or end of the last STOP when there is no MTBF.
  assign frame_done = seg_done && ((state_q == ST_MTBF) ||
                      (state_q == ST_STOP && !more_slots && MTBF_BITS == 0));

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    fs_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_BREAK;
        bit_d   = '0;
        tx_d    = 1'b0;
        fs_d    = 1'b1;
      end
    end else if (bit_tick) begin
      bit_d = seg_done ? '0 : bit_q + 1'b1;
      case (state_q)
        ST_BREAK: if (seg_done) begin state_d = ST_MAB; tx_d = 1'b1; end
        ST_MAB: if (seg_done) begin
          state_d = ST_START;
          tx_d    = 1'b0;
          slot_d  = '0;
          shift_d = START_CODE;
        end
        ST_START: begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
        ST_DATA: if (seg_done) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          // Present the next slot's index a full STOP period ahead of its START.
          idx_d   = more_slots ? slot_q[8:0] : '0;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
        ST_STOP: if (seg_done) begin
          if (more_slots) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            slot_d  = slot_q + 1'b1;
            shift_d = slot_data;
          end else if (MTBF_BITS > 0) begin
            state_d = ST_MTBF;
          end
        end
        default: ;
      endcase
      if (frame_done) begin
        state_d = enable ? ST_BREAK : ST_IDLE;
        tx_d    = ~enable;
        fs_d    = enable;
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      slot_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      fs_q    <= fs_d;
    end

  assign tx          = tx_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_start = fs_q;
  assign slot_index  = idx_q;

`ifdef DMX_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  assign fcnt_d = frame_done ? fcnt_q + 16'd1 : fcnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  assign frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_dmx_transmitter.sv
// Bench for dmx_transmitter: full-size timing, small-config slot scoreboard, MTBF/frame count.
module tb_dmx_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // full-size default instance
  logic d_rst = 1'b1, d_en = 1'b0;
  logic [8:0] d_idx;
  logic d_tx, d_busy, d_fs, d_fd;
  // CLKS_PER_BIT=4, NUM_SLOTS=3, slot buffer with 4-cycle read latency
  logic s_rst = 1'b1, s_en = 1'b0;
  logic [8:0] s_idx;
  logic [7:0] s_data;
  logic s_tx, s_busy, s_fs, s_fd;
  logic [7:0] buf_pipe [4];
  // same small config plus MTBF_BITS=2
  logic m_en = 1'b0;
  logic [8:0] m_idx;
  logic [7:0] m_data;
  logic m_tx, m_busy, m_fs, m_fd;
  logic [7:0] m_hist = '0;
`ifdef DMX_FRAME_CNT_EN
  logic [15:0] d_cnt, s_cnt, m_cnt;
`endif

  always @(posedge clk) begin
    buf_pipe[0] <= 8'h10 + s_idx[7:0];
    for (int i = 1; i < 4; i++) buf_pipe[i] <= buf_pipe[i-1];
  end
  assign s_data = buf_pipe[3];
  assign m_data = 8'h10 + m_idx[7:0];
  always @(negedge clk) m_hist <= {m_hist[6:0], m_tx};

  dmx_transmitter u_def (
    .clk(clk), .reset(d_rst), .enable(d_en), .slot_index(d_idx), .slot_data(8'hA5),
    .tx(d_tx), .busy(d_busy), .frame_start(d_fs), .frame_done(d_fd)
`ifdef DMX_FRAME_CNT_EN
    , .frame_count(d_cnt)
`endif
  );

  dmx_transmitter #(.CLKS_PER_BIT(4), .NUM_SLOTS(3)) u_sm (
    .clk(clk), .reset(s_rst), .enable(s_en), .slot_index(s_idx), .slot_data(s_data),
    .tx(s_tx), .busy(s_busy), .frame_start(s_fs), .frame_done(s_fd)
`ifdef DMX_FRAME_CNT_EN
    , .frame_count(s_cnt)
`endif
  );

  dmx_transmitter #(.CLKS_PER_BIT(4), .NUM_SLOTS(3), .MTBF_BITS(2)) u_mt (
    .clk(clk), .reset(s_rst), .enable(m_en), .slot_index(m_idx), .slot_data(m_data),
    .tx(m_tx), .busy(m_busy), .frame_start(m_fs), .frame_done(m_fd)
`ifdef DMX_FRAME_CNT_EN
    , .frame_count(m_cnt)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic [8:0] idx;
  } slot_exp_t;
  slot_exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_frame();
    exp_q.push_back('{data: 8'h00, idx: 9'd0});
    for (int k = 1; k <= 3; k++)
      exp_q.push_back('{data: 8'(8'h10 + k - 1), idx: 9'(k - 1)});
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0: return s_fs;
      1: return s_fd;
      2: return m_fs;
      3: return m_fd;
      4: return s_idx == 9'd1;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int lim, input string nm);
    int n = 0;
    @(negedge clk);
    while (!probe(sel) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!probe(sel)) chk(nm, 0, 1);
  endtask

  // Scoreboard monitor: decodes every small-config frame off the line.
  initial begin : sb_mon
    int n;
    logic [10:0] bits;
    logic [8:0] idx_at;
    slot_exp_t e;
    forever begin
      @(negedge clk);
      if (s_fs) begin
        n = 0;
        while (!s_tx && n < 200) begin n++; @(negedge clk); end
        chk("sm_break_cycles", n, 92);
        n = 0;
        while (s_tx && n < 200) begin n++; @(negedge clk); end
        chk("sm_mab_cycles", n, 12);
        for (int k = 0; k < 4; k++) begin
          idx_at = s_idx;
          repeat (2) @(negedge clk);
          for (int b = 0; b < 11; b++) begin
            bits[b] = s_tx;
            if (b < 10) repeat (4) @(negedge clk);
          end
          if (exp_q.size() == 0) chk("sm_unexpected_slot", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("sm_slot_byte", bits[8:1], e.data);
            chk("sm_slot_index", idx_at, e.idx);
            chk("sm_slot_framing", {bits[10:9], bits[0]}, 3'b110);
          end
          if (k < 3) repeat (2) @(negedge clk);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t1, t2, n, nfd;
    logic [10:0] bits;
    repeat (3) @(negedge clk);
    chk("d_rst_tx", d_tx, 1);      chk("d_rst_busy", d_busy, 0);
    chk("d_rst_fs", d_fs, 0);      chk("d_rst_fd", d_fd, 0);
    chk("d_rst_idx", d_idx, 0);    chk("s_rst_tx", s_tx, 1);
    chk("s_rst_busy", s_busy, 0);  chk("s_rst_idx", s_idx, 0);
`ifdef DMX_FRAME_CNT_EN
    chk("m_rst_count", m_cnt, 0);
`endif
    d_rst = 1'b0; s_rst = 1'b0;
    repeat (6) @(negedge clk);

    // single frame from a one-cycle enable pulse
    push_frame();
    s_en = 1'b1; @(negedge clk); s_en = 1'b0;
    chk("sm_single_fs", s_fs, 1);
    wait_for(1, 400, "sm_single_fd_timeout");
    @(negedge clk);
    chk("sm_single_idle_busy", s_busy, 0);
    chk("sm_single_idle_tx", s_tx, 1);

    // continuous run: back-to-back frames, 280-cycle period
    repeat (3) push_frame();
    s_en = 1'b1;
    wait_for(0, 50, "sm_cont_fs_timeout"); t1 = cyc;
    wait_for(1, 400, "sm_cont_fd1_timeout");
    @(negedge clk); chk("sm_b2b_fs1", s_fs, 1);
    t2 = cyc; chk("sm_period1", t2 - t1, 280);
    wait_for(1, 400, "sm_cont_fd2_timeout");
    @(negedge clk); chk("sm_b2b_fs2", s_fs, 1);
    chk("sm_period2", cyc - t2, 280);
    s_en = 1'b0;
    wait_for(1, 400, "sm_cont_fd3_timeout");
    @(negedge clk); chk("sm_cont_end_busy", s_busy, 0); chk("sm_cont_end_fs", s_fs, 0);

    // enable dropped during slot 2: frame still completes
    push_frame();
    s_en = 1'b1;
    wait_for(0, 50, "sm_drop_fs_timeout");
    wait_for(4, 300, "sm_drop_idx_timeout");
    repeat (12) @(negedge clk);
    s_en = 1'b0;
    n = 0; nfd = 0;
    while (s_busy && n < 400) begin
      if (s_fd) nfd++;
      @(negedge clk); n++;
    end
    chk("sm_drop_done_pulses", nfd, 1);
    chk("sm_drop_idle_busy", s_busy, 0);
    chk("sm_drop_idle_tx", s_tx, 1);
    repeat (20) @(negedge clk);
    chk("sm_drop_stays_idle", s_busy, 0);
    chk("sb_queue_empty", exp_q.size(), 0);

    // full-size defaults: BREAK/MAB timing and start-code slot
    d_en = 1'b1; @(negedge clk); d_en = 1'b0;
    chk("d_fs_first", d_fs, 1); chk("d_busy", d_busy, 1);
    n = 0; nfd = 0;
    while (!d_tx && n < 3000) begin
      if (d_fs) nfd++;
      n++; @(negedge clk);
    end
    chk("d_break_cycles", n, 2484); chk("d_fs_pulses", nfd, 1);
    n = 0;
    while (d_tx && n < 1000) begin n++; @(negedge clk); end
    chk("d_mab_cycles", n, 324);
    repeat (54) @(negedge clk);
    for (int b = 0; b < 11; b++) begin
      bits[b] = d_tx;
      if (b < 10) repeat (108) @(negedge clk);
    end
    chk("d_startcode_slot", bits, 11'b110_0000_0000);
    // into data bit 1 of slot 1 (0xA5 -> line 0), then reset between edges
    repeat (300) @(negedge clk);
    chk("d_mid_data_tx", d_tx, 0);
    #2 d_rst = 1'b1;
    #1;
    chk("d_async_rst_tx", d_tx, 1); chk("d_async_rst_busy", d_busy, 0);
    @(negedge clk);
    d_rst = 1'b0; d_en = 1'b1;
    @(negedge clk); d_en = 1'b0;
    chk("d_restart_fs", d_fs, 1);
    n = 0;
    while (!d_tx && n < 3000) begin n++; @(negedge clk); end
    chk("d_restart_break_cycles", n, 2484);

    // MTBF_BITS=2: 288-cycle frames, marking before each frame_done
    m_en = 1'b1;
    wait_for(2, 50, "mt_fs_timeout"); t1 = cyc;
    for (int f = 1; f <= 3; f++) begin
      if (f == 3) m_en = 1'b0;
      wait_for(3, 400, "mt_fd_timeout");
      chk("mt_mark_before_fd", {m_hist, m_tx}, 9'h1FF);
      chk("mt_fd_offset", cyc - t1, 287);
      @(negedge clk);
`ifdef DMX_FRAME_CNT_EN
      chk("mt_frame_count", m_cnt, f);
`endif
      chk("mt_next_fs", m_fs, (f < 3) ? 1 : 0);
      t1 = cyc;
    end
    chk("mt_end_busy", m_busy, 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
